// File: rtl/ahb_gpio_slave_pkg.sv
// Shared definitions for the AHB GPIO responder: transfer size, register word indices,
// response FSM states and the decode helper.
package ahb_gpio_slave_pkg;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [5:0] IDX_LED    = 6'd0;  // 0x00
  localparam logic [5:0] IDX_SW     = 6'd1;  // 0x04
  localparam logic [5:0] IDX_SW_CHG = 6'd2;  // 0x08
  localparam logic [5:0] IDX_IRQ_EN = 6'd3;  // 0x0C

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  function automatic logic xfer_legal(input logic [5:0] idx, input logic [2:0] size);
    return (idx <= IDX_IRQ_EN) && (size == HSIZE_WORD);
  endfunction

endpackage

// File: rtl/ahb_gpio_slave_sw_sync_edge.sv
// Two-flop synchroniser for the switch inputs plus a per-bit change pulse
// against the previous synchronised value.
module ahb_gpio_slave_sw_sync_edge (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sw_i,
  output logic [31:0] sw_o,
  output logic [31:0] chg_o
);

  logic [31:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // prev_q is what software reads, so the change bit lands in the same cycle as the value
  assign chg_o = sync2_q ^ prev_q;
  assign sw_o  = prev_q;

endmodule

// File: rtl/ahb_gpio_slave.sv
// AHB-Lite GPIO responder: LED register, synchronised switch readback,
// sticky switch-change status with interrupt enable and a registered irq.
//
// state   | meaning
// IDLE    | no data phase in progress, HREADYOUT=1
// WAIT    | OKAY transfer stalling, counter runs down to zero
// DONE    | OKAY data phase completes, write commits on this edge
// ERR1    | first ERROR cycle, HREADYOUT=0
// ERR2    | second ERROR cycle, HREADYOUT=1
module ahb_gpio_slave
  import ahb_gpio_slave_pkg::*;
#(
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] LED_RESET   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [7:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic [31:0] SW,
  output logic [31:0] LED,
  output logic        irq
);

  localparam logic [1:0] WS_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [5:0]  addr_q;
  logic        write_q;
  logic [31:0] led_q, chg_q, en_q;
  logic        irq_q;
  logic [31:0] sw_sync, sw_chg, chg_clr;
  logic        accept, legal, wr_en;
  logic [2:0]  unused_bits;

  assign unused_bits = {HADDR[1:0], HTRANS[0]};
  assign accept      = HSEL & HREADY & HTRANS[1];
  assign legal       = xfer_legal(HADDR[7:2], HSIZE);

  ahb_gpio_slave_sw_sync_edge u_sw (
    .clk   (clk),
    .reset (reset),
    .sw_i  (SW),
    .sw_o  (sw_sync),
    .chg_o (sw_chg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= HADDR[7:2];
        write_q <= HWRITE;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        HRESP = (state_q == ST_ERR2);
        if (!accept)                state_d = ST_IDLE;
        else if (!legal)            state_d = ST_ERR1;
        else if (WAIT_STATES == 0)  state_d = ST_DONE;
        else begin
          state_d = ST_WAIT;
          cnt_d   = WS_LOAD;
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q == 2'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_en   = (state_q == ST_DONE) && write_q;
  assign chg_clr = (wr_en && addr_q == IDX_SW_CHG) ? HWDATA : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= LED_RESET;
      chg_q <= '0;
      en_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr_en && addr_q == IDX_LED)    led_q <= HWDATA;
      if (wr_en && addr_q == IDX_IRQ_EN) en_q  <= HWDATA;
      // OR-ing the new pulses after the clear lets a same-cycle toggle survive W1C
      chg_q <= (chg_q & ~chg_clr) | sw_chg;
      irq_q <= |(chg_q & en_q);
    end
  end

  always_comb begin
    HRDATA = '0;
    if (state_q == ST_DONE && !write_q) begin
      case (addr_q)
        IDX_LED:    HRDATA = led_q;
        IDX_SW:     HRDATA = sw_sync;
        IDX_SW_CHG: HRDATA = chg_q;
        IDX_IRQ_EN: HRDATA = en_q;
        default:    HRDATA = '0;
      endcase
    end
  end

  assign LED = led_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_ahb_gpio_slave.sv
// Directed bench for ahb_gpio_slave: one instance with one wait state, one with none
// for the back-to-back case; each instance sees its own HREADYOUT as HREADY.
module tb_ahb_gpio_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel, sel0;
  logic [7:0]  haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata, sw;

  logic [31:0] hrdata1, hrdata0, led1, led0;
  logic        ro1, ro0, resp1, resp0, irq1, irq0;
  logic        hsel1, hsel0;

  logic [31:0] hrdata_m;
  logic        ro_m, resp_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign hsel1    = hsel & ~sel0;
  assign hsel0    = hsel & sel0;
  assign hrdata_m = sel0 ? hrdata0 : hrdata1;
  assign ro_m     = sel0 ? ro0 : ro1;
  assign resp_m   = sel0 ? resp0 : resp1;

  ahb_gpio_slave #(.WAIT_STATES(1), .LED_RESET(32'h0)) dut1 (
    .clk(clk), .reset(reset), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro1),
    .HRDATA(hrdata1), .HREADYOUT(ro1), .HRESP(resp1), .SW(sw), .LED(led1), .irq(irq1)
  );

  ahb_gpio_slave #(.WAIT_STATES(0), .LED_RESET(32'h0)) dut0 (
    .clk(clk), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro0),
    .HRDATA(hrdata0), .HREADYOUT(ro0), .HRESP(resp0), .SW(sw), .LED(led0), .irq(irq0)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the slave idle; returns at posedge+1 with the slave idle again.
  task automatic xfer(input logic [7:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic rsp_low, output logic rsp_end, output int nwait);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    nwait = 0; rsp_low = 1'b0;
    while (ro_m == 1'b0 && nwait < 20) begin
      rsp_low = rsp_low | resp_m;
      nwait++;
      @(posedge clk); #1;
    end
    rd = hrdata_m; rsp_end = resp_m;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        rl, re;
  int          nw;

  initial begin
    reset = 1'b1; hsel = 1'b0; sel0 = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'b010; hwdata = '0; sw = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk1 ("rst_hreadyout", ro1, 1'b1);
    chk1 ("rst_hresp", resp1, 1'b0);
    chk32("rst_hrdata", hrdata1, 32'h0);
    chk32("rst_led", led1, 32'h0);
    chk1 ("rst_irq", irq1, 1'b0);

    hsel = 1'b1; htrans = 2'b00; haddr = 8'h00;
    @(posedge clk); #1;
    chk1 ("idle_xfer_ready", ro1, 1'b1);
    chk1 ("idle_xfer_resp", resp1, 1'b0);
    hsel = 1'b0;

    xfer(8'h00, 1'b0, 3'b010, 32'h0, rd, rl, re, nw);
    chk32("rd_led_reset", rd, 32'h0);
    chk32("rd_led_waits", nw, 1);
    chk1 ("rd_led_resp", re, 1'b0);

    xfer(8'h00, 1'b1, 3'b010, 32'hA5A5_0F0F, rd, rl, re, nw);
    chk32("wr_led_waits", nw, 1);
    chk32("wr_led_out", led1, 32'hA5A5_0F0F);
    xfer(8'h00, 1'b0, 3'b010, 32'h0, rd, rl, re, nw);
    chk32("rb_led", rd, 32'hA5A5_0F0F);

    sw = 32'h0000_0003;
    xfer(8'h04, 1'b0, 3'b010, 32'h0, rd, rl, re, nw);
    chk32("sw_too_early", rd, 32'h0);
    xfer(8'h04, 1'b0, 3'b010, 32'h0, rd, rl, re, nw);
    chk32("sw_value", rd, 32'h3);
    xfer(8'h08, 1'b0, 3'b010, 32'h0, rd, rl, re, nw);
    chk32("sw_chg", rd, 32'h3);
    chk1 ("irq_disabled", irq1, 1'b0);

    xfer(8'h0C, 1'b1, 3'b010, 32'h1, rd, rl, re, nw);
    chk1 ("irq_not_yet", irq1, 1'b0);
    @(posedge clk); #1;
    chk1 ("irq_set", irq1, 1'b1);

    xfer(8'h08, 1'b1, 3'b010, 32'h1, rd, rl, re, nw);
    chk1 ("irq_still", irq1, 1'b1);
    @(posedge clk); #1;
    chk1 ("irq_cleared", irq1, 1'b0);
    xfer(8'h08, 1'b0, 3'b010, 32'h0, rd, rl, re, nw);
    chk32("sw_chg_w1c", rd, 32'h2);

    xfer(8'h20, 1'b0, 3'b010, 32'h0, rd, rl, re, nw);
    chk32("err_rd_low_cycles", nw, 1);
    chk1 ("err_rd_err1", rl, 1'b1);
    chk1 ("err_rd_err2", re, 1'b1);
    chk32("err_rd_data", rd, 32'h0);

    xfer(8'h00, 1'b1, 3'b001, 32'h1234_5678, rd, rl, re, nw);
    chk32("err_hw_low_cycles", nw, 1);
    chk1 ("err_hw_err1", rl, 1'b1);
    chk1 ("err_hw_err2", re, 1'b1);
    chk32("err_hw_led", led1, 32'hA5A5_0F0F);

    sel0 = 1'b1;
    hsel = 1'b1; htrans = 2'b10; haddr = 8'h0C; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    chk1 ("b2b_wr_ready", ro0, 1'b1);
    hwdata = 32'h0000_00C3; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    chk1 ("b2b_rd_ready", ro0, 1'b1);
    chk1 ("b2b_rd_resp", resp0, 1'b0);
    chk32("b2b_rd_data", hrdata0, 32'h0000_00C3);
    @(posedge clk); #1;
    sel0 = 1'b0;

    hsel = 1'b1; htrans = 2'b10; haddr = 8'h00; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    chk1 ("abort_in_wait", ro1, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk1 ("abort_ready", ro1, 1'b1);
    chk32("abort_led", led1, 32'h0);
    @(posedge clk); #1;
    chk32("abort_led_later", led1, 32'h0);
    chk1 ("abort_resp", resp1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
